// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_ctrl
//  Purpose  : Button-driven time-setting controller for a sec/min/hr counter
//             chain. RUN enables the chain; mode presses walk through the
//             hour, minute and second edit states where inc/dec adjust shadow
//             copies of the time (with hold-to-repeat). Leaving the second
//             edit state issues a one-cycle load of the shadows.
//  Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
    parameter int unsigned HOLD_CYC  = 500_000,
    parameter int unsigned RPT_CYC   = 100_000,
    parameter int unsigned BLINK_CYC = 250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       btn_dec_i,
    input  logic [5:0] cur_sec_i,
    input  logic [5:0] cur_min_i,
    input  logic [4:0] cur_hr_i,
    output logic       run_en_o,
    output logic       ld_o,
    output logic [5:0] ld_sec_o,
    output logic [5:0] ld_min_o,
    output logic [4:0] ld_hr_o,
    output logic [1:0] edit_sel_o,
    output logic       blink_o
);

    // Counter widths: the repeat counter must reach the larger of the hold
    // and repeat intervals; the blink counter only reaches BLINK_CYC-1.
    localparam int unsigned RPT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int unsigned RCW     = $clog2(RPT_MAX + 1);
    localparam int unsigned BCW     = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [RCW-1:0] RCNT_ONE  = RCW'(1);
    localparam logic [RCW-1:0] RCNT_HOLD = RCW'(HOLD_CYC);
    localparam logic [RCW-1:0] RCNT_RPT  = RCW'(RPT_CYC);
    localparam logic [BCW-1:0] BCNT_ONE  = BCW'(1);
    localparam logic [BCW-1:0] BCNT_LAST = BCW'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_HR  = 2'd1,
        ST_MIN = 2'd2,
        ST_SEC = 2'd3
    } state_t;

    // Auto-repeat tracker: IDLE until a qualified press, then HOLD waits the
    // initial delay, then RPT steps at the repeat interval.
    typedef enum logic [1:0] {
        RP_IDLE = 2'd0,
        RP_HOLD = 2'd1,
        RP_RPT  = 2'd2
    } rpt_t;

    state_t         state_q, state_d;
    rpt_t           rpt_st_q, rpt_st_d;
    logic [RCW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_q, blink_d;
    logic           ld_q, ld_d;
    logic           mode_q, inc_q, dec_q;
    logic [5:0]     sec_q, sec_d;
    logic [5:0]     min_q, min_d;
    logic [4:0]     hr_q, hr_d;

    logic w_mode_press, w_inc_press, w_dec_press;
    logic w_up, w_dn, w_edit, w_step;

    // Step a 0..59 field up or down with wrap-around.
    function automatic logic [5:0] f_step60(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    endfunction

    // Step a 0..23 field up or down with wrap-around.
    function automatic logic [4:0] f_step24(input logic [4:0] v, input logic up);
        if (up) return (v >= 5'd23) ? 5'd0 : v + 5'd1;
        else    return (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
    endfunction

    // Rising-edge detection on the debounced buttons; a lone inc or dec
    // level is the only thing that may adjust (both together cancel).
    assign w_mode_press = btn_mode_i & ~mode_q;
    assign w_inc_press  = btn_inc_i  & ~inc_q;
    assign w_dec_press  = btn_dec_i  & ~dec_q;
    assign w_up         = btn_inc_i  & ~btn_dec_i;
    assign w_dn         = btn_dec_i  & ~btn_inc_i;
    assign w_edit       = (state_q != ST_RUN);

    // Mode sequencing; the load strobe is raised for the first RUN cycle.
    always_comb begin
        state_d = state_q;
        ld_d    = 1'b0;
        if (w_mode_press) begin
            case (state_q)
                ST_RUN:  state_d = ST_HR;
                ST_HR:   state_d = ST_MIN;
                ST_MIN:  state_d = ST_SEC;
                default: begin
                    state_d = ST_RUN;
                    ld_d    = 1'b1;
                end
            endcase
        end
    end

    // Adjust step generation: press step, then initial hold delay, then
    // periodic repeat. Mode press, release, RUN or inc+dec all disarm it so
    // a still-held button never steps the newly selected field.
    always_comb begin
        rpt_st_d  = rpt_st_q;
        rpt_cnt_d = rpt_cnt_q;
        w_step    = 1'b0;
        if (!w_edit || w_mode_press || !(w_up || w_dn)) begin
            rpt_st_d  = RP_IDLE;
            rpt_cnt_d = '0;
        end else if ((w_up && w_inc_press) || (w_dn && w_dec_press)) begin
            w_step    = 1'b1;
            rpt_st_d  = RP_HOLD;
            rpt_cnt_d = RCNT_ONE;
        end else begin
            case (rpt_st_q)
                RP_HOLD: begin
                    if (rpt_cnt_q == RCNT_HOLD) begin
                        w_step    = 1'b1;
                        rpt_st_d  = RP_RPT;
                        rpt_cnt_d = RCNT_ONE;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RCNT_ONE;
                    end
                end
                RP_RPT: begin
                    if (rpt_cnt_q == RCNT_RPT) begin
                        w_step    = 1'b1;
                        rpt_cnt_d = RCNT_ONE;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RCNT_ONE;
                    end
                end
                default: begin
                    rpt_st_d  = RP_IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    // Shadow time: sanitised capture on entering edit, then field steps.
    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (state_q == ST_RUN && w_mode_press) begin
            hr_d  = (cur_hr_i  > 5'd23) ? 5'd0 : cur_hr_i;
            min_d = (cur_min_i > 6'd59) ? 6'd0 : cur_min_i;
            sec_d = (cur_sec_i > 6'd59) ? 6'd0 : cur_sec_i;
        end else if (w_step) begin
            case (state_q)
                ST_HR:   hr_d  = f_step24(hr_q, w_up);
                ST_MIN:  min_d = f_step60(min_q, w_up);
                ST_SEC:  sec_d = f_step60(sec_q, w_up);
                default: ;
            endcase
        end
    end

    // Blink generator: restarts high on every state change, held low in RUN.
    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (state_d != state_q) begin
            blink_d     = (state_d != ST_RUN);
            blink_cnt_d = '0;
        end else if (!w_edit) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BCNT_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BCNT_ONE;
        end
    end

    // State, counters, shadows and button history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            rpt_st_q    <= RP_IDLE;
            rpt_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            ld_q        <= 1'b0;
            mode_q      <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
        end else begin
            state_q     <= state_d;
            rpt_st_q    <= rpt_st_d;
            rpt_cnt_q   <= rpt_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            ld_q        <= ld_d;
            mode_q      <= btn_mode_i;
            inc_q       <= btn_inc_i;
            dec_q       <= btn_dec_i;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
        end
    end

    assign run_en_o   = (state_q == ST_RUN);
    assign ld_o       = ld_q;
    assign ld_sec_o   = sec_q;
    assign ld_min_o   = min_q;
    assign ld_hr_o    = hr_q;
    assign edit_sel_o = state_q;
    assign blink_o    = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_set_ctrl
//  Purpose  : Directed self-checking bench for time_set_ctrl using short
//             hold/repeat/blink intervals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [5:0] cur_sec = '0;
    logic [5:0] cur_min = '0;
    logic [4:0] cur_hr = '0;
    logic       run_en, ld, blink;
    logic [5:0] ld_sec, ld_min;
    logic [4:0] ld_hr;
    logic [1:0] edit_sel;

    int n_chk  = 0;
    int n_fail = 0;

    time_set_ctrl #(.HOLD_CYC(8), .RPT_CYC(3), .BLINK_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode_i (btn_mode),
        .btn_inc_i  (btn_inc),
        .btn_dec_i  (btn_dec),
        .cur_sec_i  (cur_sec),
        .cur_min_i  (cur_min),
        .cur_hr_i   (cur_hr),
        .run_en_o   (run_en),
        .ld_o       (ld),
        .ld_sec_o   (ld_sec),
        .ld_min_o   (ld_min),
        .ld_hr_o    (ld_hr),
        .edit_sel_o (edit_sel),
        .blink_o    (blink)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mode_down();
        btn_mode = 1'b1;
        tick();
    endtask

    task automatic mode_up();
        btn_mode = 1'b0;
        tick();
    endtask

    task automatic inc_pulse();
        btn_inc = 1'b1; tick();
        btn_inc = 1'b0; tick();
    endtask

    task automatic dec_pulse();
        btn_dec = 1'b1; tick();
        btn_dec = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(2);
        n_chk++; if (run_en !== 1'b1)   begin n_fail++; $display("FAIL reset_run_en: got %0d want 1", run_en); end
        n_chk++; if (ld !== 1'b0)       begin n_fail++; $display("FAIL reset_ld: got %0d want 0", ld); end
        n_chk++; if (edit_sel !== 2'd0) begin n_fail++; $display("FAIL reset_edit_sel: got %0d want 0", edit_sel); end
        n_chk++; if (blink !== 1'b0)    begin n_fail++; $display("FAIL reset_blink: got %0d want 0", blink); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mode_sequence();
        cur_hr = 5'd13; cur_min = 6'd45; cur_sec = 6'd7;
        mode_down();
        n_chk++; if (edit_sel !== 2'd1) begin n_fail++; $display("FAIL seq_edit_hr: got %0d want 1", edit_sel); end
        n_chk++; if (run_en !== 1'b0)   begin n_fail++; $display("FAIL seq_run_en_hr: got %0d want 0", run_en); end
        n_chk++; if (blink !== 1'b1)    begin n_fail++; $display("FAIL seq_blink_start: got %0d want 1", blink); end
        mode_up();
        ticks(2);
        n_chk++; if (blink !== 1'b1)    begin n_fail++; $display("FAIL seq_blink_3: got %0d want 1", blink); end
        tick();
        n_chk++; if (blink !== 1'b0)    begin n_fail++; $display("FAIL seq_blink_4: got %0d want 0", blink); end
        mode_down();
        n_chk++; if (edit_sel !== 2'd2) begin n_fail++; $display("FAIL seq_edit_min: got %0d want 2", edit_sel); end
        n_chk++; if (blink !== 1'b1)    begin n_fail++; $display("FAIL seq_blink_reload: got %0d want 1", blink); end
        n_chk++; if (ld !== 1'b0)       begin n_fail++; $display("FAIL seq_ld_min: got %0d want 0", ld); end
        mode_up();
        mode_down();
        n_chk++; if (edit_sel !== 2'd3) begin n_fail++; $display("FAIL seq_edit_sec: got %0d want 3", edit_sel); end
        n_chk++; if (run_en !== 1'b0)   begin n_fail++; $display("FAIL seq_run_en_sec: got %0d want 0", run_en); end
        mode_up();
        mode_down();
        n_chk++; if (edit_sel !== 2'd0) begin n_fail++; $display("FAIL seq_edit_run: got %0d want 0", edit_sel); end
        n_chk++; if (ld !== 1'b1)       begin n_fail++; $display("FAIL seq_ld_pulse: got %0d want 1", ld); end
        n_chk++; if (run_en !== 1'b1)   begin n_fail++; $display("FAIL seq_run_en_ld: got %0d want 1", run_en); end
        n_chk++; if (ld_hr !== 5'd13)   begin n_fail++; $display("FAIL seq_ld_hr: got %0d want 13", ld_hr); end
        n_chk++; if (ld_min !== 6'd45)  begin n_fail++; $display("FAIL seq_ld_min_val: got %0d want 45", ld_min); end
        n_chk++; if (ld_sec !== 6'd7)   begin n_fail++; $display("FAIL seq_ld_sec: got %0d want 7", ld_sec); end
        n_chk++; if (blink !== 1'b0)    begin n_fail++; $display("FAIL seq_blink_run: got %0d want 0", blink); end
        mode_up();
        n_chk++; if (ld !== 1'b0)       begin n_fail++; $display("FAIL seq_ld_single: got %0d want 0", ld); end
    endtask

    task automatic test_wrap_and_hold();
        cur_hr = 5'd23; cur_min = 6'd0; cur_sec = 6'd10;
        mode_down(); mode_up();
        inc_pulse();
        n_chk++; if (ld_hr !== 5'd0)    begin n_fail++; $display("FAIL wrap_hr_inc: got %0d want 0", ld_hr); end
        mode_down(); mode_up();
        dec_pulse();
        n_chk++; if (ld_min !== 6'd59)  begin n_fail++; $display("FAIL wrap_min_dec: got %0d want 59", ld_min); end
        mode_down(); mode_up();
        btn_inc = 1'b1;
        tick();
        n_chk++; if (ld_sec !== 6'd11)  begin n_fail++; $display("FAIL hold_t1: got %0d want 11", ld_sec); end
        ticks(7);
        n_chk++; if (ld_sec !== 6'd11)  begin n_fail++; $display("FAIL hold_t8: got %0d want 11", ld_sec); end
        tick();
        n_chk++; if (ld_sec !== 6'd12)  begin n_fail++; $display("FAIL hold_t9: got %0d want 12", ld_sec); end
        ticks(3);
        n_chk++; if (ld_sec !== 6'd13)  begin n_fail++; $display("FAIL hold_t12: got %0d want 13", ld_sec); end
        ticks(8);
        n_chk++; if (ld_sec !== 6'd15)  begin n_fail++; $display("FAIL hold_t20: got %0d want 15", ld_sec); end
        btn_inc = 1'b0;
        ticks(10);
        n_chk++; if (ld_sec !== 6'd15)  begin n_fail++; $display("FAIL hold_release: got %0d want 15", ld_sec); end
        n_chk++; if (run_en !== 1'b0)   begin n_fail++; $display("FAIL hold_run_en: got %0d want 0", run_en); end
        mode_down();
        n_chk++; if (ld !== 1'b1)       begin n_fail++; $display("FAIL hold_ld: got %0d want 1", ld); end
        n_chk++; if ({ld_hr, ld_min, ld_sec} !== {5'd0, 6'd59, 6'd15})
            begin n_fail++; $display("FAIL hold_ld_time: got %0d:%0d:%0d want 0:59:15", ld_hr, ld_min, ld_sec); end
        mode_up();
    endtask

    task automatic test_simultaneous();
        cur_hr = 5'd5; cur_min = 6'd20; cur_sec = 6'd30;
        mode_down(); mode_up();
        btn_inc = 1'b1; btn_dec = 1'b1;
        ticks(12);
        btn_inc = 1'b0; btn_dec = 1'b0;
        tick();
        n_chk++; if (ld_hr !== 5'd5)    begin n_fail++; $display("FAIL both_hr: got %0d want 5", ld_hr); end
        n_chk++; if (edit_sel !== 2'd1) begin n_fail++; $display("FAIL both_state: got %0d want 1", edit_sel); end
        btn_mode = 1'b1; btn_inc = 1'b1;
        tick();
        n_chk++; if (edit_sel !== 2'd2) begin n_fail++; $display("FAIL modeinc_state: got %0d want 2", edit_sel); end
        n_chk++; if (ld_hr !== 5'd5)    begin n_fail++; $display("FAIL modeinc_hr: got %0d want 5", ld_hr); end
        n_chk++; if (ld_min !== 6'd20)  begin n_fail++; $display("FAIL modeinc_min: got %0d want 20", ld_min); end
        btn_mode = 1'b0;
        ticks(12);
        n_chk++; if (ld_min !== 6'd20)  begin n_fail++; $display("FAIL modeinc_held: got %0d want 20", ld_min); end
        btn_inc = 1'b0;
        tick();
        inc_pulse();
        n_chk++; if (ld_min !== 6'd21)  begin n_fail++; $display("FAIL modeinc_newpress: got %0d want 21", ld_min); end
        mode_down(); mode_up();
        mode_down(); mode_up();
        n_chk++; if (edit_sel !== 2'd0) begin n_fail++; $display("FAIL simul_back_run: got %0d want 0", edit_sel); end
        inc_pulse();
        dec_pulse();
        n_chk++; if (ld_hr !== 5'd5 || ld_min !== 6'd21 || ld_sec !== 6'd30)
            begin n_fail++; $display("FAIL run_ignore: got %0d:%0d:%0d want 5:21:30", ld_hr, ld_min, ld_sec); end
        n_chk++; if (ld !== 1'b0)       begin n_fail++; $display("FAIL run_ignore_ld: got %0d want 0", ld); end
    endtask

    task automatic test_reset_mid_edit();
        int ld_seen;
        cur_hr = 5'd27; cur_min = 6'd10; cur_sec = 6'd60;
        mode_down(); mode_up();
        n_chk++; if ({ld_hr, ld_min, ld_sec} !== {5'd0, 6'd10, 6'd0})
            begin n_fail++; $display("FAIL capture_range: got %0d:%0d:%0d want 0:10:0", ld_hr, ld_min, ld_sec); end
        dec_pulse();
        n_chk++; if (ld_hr !== 5'd23)   begin n_fail++; $display("FAIL wrap_hr_dec: got %0d want 23", ld_hr); end
        mode_down(); mode_up();
        n_chk++; if (edit_sel !== 2'd2) begin n_fail++; $display("FAIL mid_state: got %0d want 2", edit_sel); end
        rst = 1'b1;
        tick();
        n_chk++; if (edit_sel !== 2'd0 || run_en !== 1'b1)
            begin n_fail++; $display("FAIL mid_rst_state: got sel=%0d en=%0d want sel=0 en=1", edit_sel, run_en); end
        n_chk++; if (ld_hr !== 5'd0)    begin n_fail++; $display("FAIL mid_rst_shadow: got %0d want 0", ld_hr); end
        ld_seen = 0;
        if (ld === 1'b1) ld_seen++;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ld === 1'b1) ld_seen++;
        end
        n_chk++; if (ld_seen !== 0)     begin n_fail++; $display("FAIL mid_rst_no_ld: got %0d pulses want 0", ld_seen); end
        mode_down(); mode_up();
        mode_down(); mode_up();
        mode_down(); mode_up();
        mode_down();
        n_chk++; if (ld !== 1'b1)       begin n_fail++; $display("FAIL oor_ld: got %0d want 1", ld); end
        n_chk++; if ({ld_hr, ld_min, ld_sec} !== {5'd0, 6'd10, 6'd0})
            begin n_fail++; $display("FAIL oor_ld_time: got %0d:%0d:%0d want 0:10:0", ld_hr, ld_min, ld_sec); end
        mode_up();
    endtask

    initial begin
        test_reset();
        test_mode_sequence();
        test_wrap_and_hold();
        test_simultaneous();
        test_reset_mid_edit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
